// File: rtl/seg595_scan_ctrl_pkg.sv
// Shared constants and helpers for the 74HC595 seven-segment scan controller.
// Frame word layout is {seg[7:0], sel[7:0]}; segments are active-low, seg[7] is the decimal point.
`timescale 1ns/1ps
package seg595_scan_ctrl_pkg;

  localparam int FRAME_W = 16;
  localparam logic [7:0] SEG_BLANK   = 8'hff;
  localparam logic [7:0] SEG_DP_MASK = 8'h7f;

  typedef logic [FRAME_W-1:0] frame_t;
  typedef logic [7:0]         seg_t;

  function automatic logic [7:0] sel_onehot(input logic [2:0] idx);
    return 8'h01 << idx;
  endfunction

  // Lighting the decimal point means clearing the active-low seg[7].
  function automatic seg_t apply_dp(input seg_t seg, input logic dp);
    return dp ? (seg & SEG_DP_MASK) : seg;
  endfunction

endpackage

// File: rtl/seg595_scan_ctrl_if.sv
// Digit data in, 74HC595 pin drive and frame status out.
// master = time/format logic side, slave = the scan controller.
`timescale 1ns/1ps
interface seg595_scan_ctrl_if #(
  parameter int DIGITS = 8
) ();
  logic                  scan_en;
  logic [4*DIGITS-1:0]   data_in;
  logic [DIGITS-1:0]     dp_en;
  logic                  ser;
  logic                  sclk;
  logic                  rclk;
  logic [2:0]            digit_idx;
  logic                  frame_done;

  modport master (
    output scan_en, data_in, dp_en,
    input  ser, sclk, rclk, digit_idx, frame_done
  );

  modport slave (
    input  scan_en, data_in, dp_en,
    output ser, sclk, rclk, digit_idx, frame_done
  );
endinterface

// File: rtl/seg595_scan_ctrl_decode_bcd.sv
// BCD nibble to active-low seven-segment pattern {dp, g, f, e, d, c, b, a}.
// 0-9 give digits, 4'ha gives a dash, everything else is blank. The dp bit is always off here.
`timescale 1ns/1ps
module decode_bcd
  import seg595_scan_ctrl_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = 8'hc0;
      4'd1:    seg = 8'hf9;
      4'd2:    seg = 8'ha4;
      4'd3:    seg = 8'hb0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hf8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      4'ha:    seg = 8'hbf;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg595_scan_ctrl.sv
// Scans DIGITS seven-segment digits through a 74HC595 chain: IDLE dwell, LOAD one frame word,
// SHIFT it out MSB first on sclk, then LATCH with rclk and advance to the next digit.
`timescale 1ns/1ps
module seg595_scan_ctrl
  import seg595_scan_ctrl_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int CLK_DIV     = 2,
  parameter int SCAN_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst,
  seg595_scan_ctrl_if.slave  bus
);

  localparam int DWELL_W = $clog2(SCAN_CYCLES + 1);
  localparam int DIV_W   = $clog2(CLK_DIV + 1);

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_CYCLES - 1);
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]         BIT_LAST   = 4'(FRAME_W - 1);
  localparam logic [2:0]         DIGIT_LAST = 3'(DIGITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_LATCH = 2'd3;

  logic [1:0]         state;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [DIV_W-1:0]   div_cnt;
  logic [3:0]         bit_cnt;
  logic               div_last;

  logic [3:0] nibble_p0;
  logic       dp_p0;
  seg_t       dec_seg_p0;
  frame_t     word_p0;
  frame_t     shreg_p1;

  logic       ser_r;
  logic       sclk_r;
  logic       rclk_r;
  logic [2:0] digit_idx_r;

  assign div_last = (div_cnt == DIV_LAST);

  // ---- LOAD stage: select current digit, decode, form {seg, sel}
  assign nibble_p0 = bus.data_in[{digit_idx_r, 2'b00} +: 4];
  assign dp_p0     = bus.dp_en[digit_idx_r];

  decode_bcd u_decode_bcd (
    .bcd (nibble_p0),
    .seg (dec_seg_p0)
  );

  assign word_p0 = {apply_dp(dec_seg_p0, dp_p0), sel_onehot(digit_idx_r)};

  // ---- SHIFT stage: frame register, rotated once per completed bit
  // Rotating instead of shifting keeps the word intact; only the top bit is ever presented.
  always_ff @(posedge clk) begin
    if (state == S_LOAD) begin
      shreg_p1 <= word_p0;
    end else if (state == S_SHIFT && div_last && sclk_r) begin
      shreg_p1 <= {shreg_p1[FRAME_W-2:0], shreg_p1[FRAME_W-1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      dwell_cnt   <= '0;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      ser_r       <= 1'b0;
      sclk_r      <= 1'b0;
      rclk_r      <= 1'b0;
      digit_idx_r <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.scan_en) begin
            if (dwell_cnt == DWELL_LAST) begin
              dwell_cnt <= '0;
              state     <= S_LOAD;
            end else begin
              dwell_cnt <= dwell_cnt + 1'b1;
            end
          end
        end
        S_LOAD: begin
          ser_r   <= word_p0[FRAME_W-1];
          sclk_r  <= 1'b0;
          div_cnt <= '0;
          bit_cnt <= '0;
          state   <= S_SHIFT;
        end
        S_SHIFT: begin
          if (div_last) begin
            div_cnt <= '0;
            if (!sclk_r) begin
              sclk_r <= 1'b1;
            end else begin
              // End of the high phase: the next bit's data goes out with sclk falling.
              sclk_r <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                ser_r  <= 1'b0;
                rclk_r <= 1'b1;
                state  <= S_LATCH;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                ser_r   <= shreg_p1[FRAME_W-2];
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_LATCH: begin
          if (div_last) begin
            div_cnt     <= '0;
            rclk_r      <= 1'b0;
            state       <= S_IDLE;
            digit_idx_r <= (digit_idx_r == DIGIT_LAST) ? 3'd0 : digit_idx_r + 3'd1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ser        = ser_r;
  assign bus.sclk       = sclk_r;
  assign bus.rclk       = rclk_r;
  assign bus.digit_idx  = digit_idx_r;
  assign bus.frame_done = (state == S_LATCH) && div_last;

endmodule

// File: tb/tb_seg595_scan_ctrl.sv
// Bench for seg595_scan_ctrl: a pin-level monitor rebuilds each frame word from ser/sclk,
// and frames are compared against a glyph-table reference model and fixed vectors.
`timescale 1ns/1ps
module tb_seg595_scan_ctrl;

  localparam int DIGITS      = 8;
  localparam int CLK_DIV     = 2;
  localparam int SCAN_CYCLES = 4;
  localparam int PERIOD      = 1 + 33 * CLK_DIV + SCAN_CYCLES;
  localparam int LATENCY     = PERIOD - 1;  // reset/enable edge to frame_done sample

  // Lit segments, active-high {g,f,e,d,c,b,a}, for nibble codes 0..15.
  localparam logic [6:0] GLYPH [16] = '{
    7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
    7'h7f, 7'h6f, 7'h40, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
  };

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg595_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

  seg595_scan_ctrl #(
    .DIGITS      (DIGITS),
    .CLK_DIV     (CLK_DIV),
    .SCAN_CYCLES (SCAN_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_word(input logic [31:0] data, input logic [7:0] dp,
                                             input int d);
    logic [3:0] nib;
    nib = data[4*d +: 4];
    return {~{dp[d], GLYPH[nib]}, 8'(1 << d)};
  endfunction

  typedef struct {
    logic [15:0] word;
    int          dig;
    int          bits;
    int          rclk_hi;
    int          fd_cyc;
  } frame_rec_t;

  frame_rec_t frames[$];
  int cyc = 0, mon_bits = 0, sclk_rises = 0, fd_total = 0;
  int glitches = 0, overlaps = 0, rclk_hi = 0;
  logic [15:0] mon_sh = '0;
  logic sclk_q = 1'b0, ser_q = 1'b0;

  // Pin monitor, sampled 1ns after each rising clk edge.
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      mon_bits = 0;
      rclk_hi  = 0;
      mon_sh   = '0;
    end else begin
      if (bus.sclk && !sclk_q) begin
        mon_sh = {mon_sh[14:0], bus.ser};
        mon_bits++;
        sclk_rises++;
        if (bus.ser !== ser_q) glitches++;
      end else if (bus.sclk && sclk_q && bus.ser !== ser_q) begin
        glitches++;
      end
      if (bus.sclk && bus.rclk) overlaps++;
      if (bus.rclk) rclk_hi++;
      if (bus.frame_done) begin
        frames.push_back('{mon_sh, int'(bus.digit_idx), mon_bits, rclk_hi, cyc});
        fd_total++;
        mon_bits = 0;
        rclk_hi  = 0;
      end
    end
    sclk_q = bus.sclk;
    ser_q  = bus.ser;
  end

  task automatic do_reset(output int t0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ser",        64'(bus.ser), 64'd0);
    check("rst_sclk",       64'(bus.sclk), 64'd0);
    check("rst_rclk",       64'(bus.rclk), 64'd0);
    check("rst_digit_idx",  64'(bus.digit_idx), 64'd0);
    check("rst_frame_done", 64'(bus.frame_done), 64'd0);
    rst = 1'b0;
    t0  = cyc;
    frames.delete();
  endtask

  task automatic wait_frame(output frame_rec_t r, output bit ok);
    int n;
    n = 0;
    while (frames.size() == 0 && n < 3 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    if (frames.size() == 0) begin
      ok = 1'b0;
      n_checks++;
      n_fail++;
      $display("FAIL frame_timeout: no frame_done within %0d cycles, required one", 3 * PERIOD);
      r = '{default: 0};
    end else begin
      ok = 1'b1;
      r  = frames.pop_front();
    end
  endtask

  task automatic wait_bits(input int n);
    int k;
    k = 0;
    while (mon_bits < n && k < 3 * PERIOD) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (mon_bits < n) begin
      n_fail++;
      $display("FAIL bit_timeout: saw %0d sclk rises, required %0d", mon_bits, n);
    end
  endtask

  task automatic check_frame(input string name, input frame_rec_t r,
                             input logic [15:0] exp_word, input int exp_dig);
    check({name, "_word"},  64'(r.word), 64'(exp_word));
    check({name, "_digit"}, 64'(r.dig), 64'(exp_dig));
    check({name, "_bits"},  64'(r.bits), 64'd16);
    check({name, "_rclk"},  64'(r.rclk_hi), 64'(CLK_DIV));
  endtask

  typedef struct {
    logic [3:0]  nib;
    logic        dp;
    logic [15:0] word;
    string       name;
  } vec_t;

  initial begin
    vec_t        vecs[6];
    logic [7:0]  seg_seq[8];
    frame_rec_t  r;
    bit          ok;
    int          t0, d_exp, prev_fd, rises, fdt, d_hit;
    logic [31:0] data_a, data_b;
    logic [7:0]  dp_a, dp_b;
    logic [15:0] exp_w, exp_hit;

    vecs[0] = '{4'd5, 1'b0, 16'h9201, "dig5"};
    vecs[1] = '{4'd8, 1'b1, 16'h0001, "dig8_dp"};
    vecs[2] = '{4'ha, 1'b0, 16'hbf01, "dash"};
    vecs[3] = '{4'hf, 1'b0, 16'hff01, "blank_f"};
    vecs[4] = '{4'hb, 1'b1, 16'h7f01, "blank_dp"};
    vecs[5] = '{4'd0, 1'b0, 16'hc001, "dig0"};
    seg_seq = '{8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92, 8'h82, 8'hf8};

    bus.scan_en = 1'b1;
    bus.data_in = '0;
    bus.dp_en   = '0;

    // Single-digit glyph vectors, each from reset on digit 0.
    for (int i = 0; i < 6; i++) begin
      bus.data_in = {28'h0, vecs[i].nib};
      bus.dp_en   = {7'h0, vecs[i].dp};
      do_reset(t0);
      wait_frame(r, ok);
      if (ok) begin
        check_frame(vecs[i].name, r, vecs[i].word, 0);
        check({vecs[i].name, "_latency"}, 64'(r.fd_cyc - t0), 64'(LATENCY));
      end
      @(negedge clk);
      check({vecs[i].name, "_fd_pulse"}, 64'(bus.frame_done), 64'd0);
      check({vecs[i].name, "_next_idx"}, 64'(bus.digit_idx), 64'd1);
    end

    // Eight-digit scan with wrap and frame spacing.
    bus.data_in = 32'h76543210;
    bus.dp_en   = '0;
    do_reset(t0);
    prev_fd = 0;
    for (int k = 0; k < 9; k++) begin
      wait_frame(r, ok);
      if (ok) begin
        check_frame($sformatf("scan%0d", k), r, {seg_seq[k % 8], 8'(1 << (k % 8))}, k % 8);
        if (k > 0) check($sformatf("scan%0d_spacing", k), 64'(r.fd_cyc - prev_fd), 64'(PERIOD));
        prev_fd = r.fd_cyc;
      end
    end
    d_exp = 1;

    // Random data, refreshed in IDLE between frames.
    for (int k = 0; k < 24; k++) begin
      data_a = $urandom;
      dp_a   = 8'($urandom);
      bus.data_in = data_a;
      bus.dp_en   = dp_a;
      exp_w = model_word(data_a, dp_a, d_exp);
      wait_frame(r, ok);
      if (ok) check_frame($sformatf("rand%0d", k), r, exp_w, d_exp);
      d_exp = (d_exp + 1) % DIGITS;
    end

    // Inputs changed mid-SHIFT do not tear the current frame.
    data_a = $urandom;
    dp_a   = 8'($urandom);
    data_b = ~data_a;
    dp_b   = ~dp_a;
    bus.data_in = data_a;
    bus.dp_en   = dp_a;
    exp_w = model_word(data_a, dp_a, d_exp);
    wait_bits(4);
    bus.data_in = data_b;
    bus.dp_en   = dp_b;
    wait_frame(r, ok);
    if (ok) check_frame("midshift_old", r, exp_w, d_exp);
    d_hit   = d_exp;
    exp_hit = model_word(data_b, dp_b, d_hit);
    d_exp = (d_exp + 1) % DIGITS;
    for (int k = 0; k < 8; k++) begin
      wait_frame(r, ok);
      if (ok && k == 7) check_frame("midshift_new", r, exp_hit, d_hit);
      else if (ok) check_frame($sformatf("after%0d", k), r, model_word(data_b, dp_b, d_exp), d_exp);
      d_exp = (d_exp + 1) % DIGITS;
    end

    // Reset mid-SHIFT aborts the frame; next frame is digit 0 after a full dwell.
    wait_bits(7);
    do_reset(t0);
    wait_frame(r, ok);
    if (ok) begin
      check_frame("post_rst", r, model_word(data_b, dp_b, 0), 0);
      check("post_rst_latency", 64'(r.fd_cyc - t0), 64'(LATENCY));
    end
    d_exp = 1;

    // scan_en dropped mid-SHIFT: frame finishes, then the chain stays idle.
    wait_bits(3);
    bus.scan_en = 1'b0;
    wait_frame(r, ok);
    if (ok) check_frame("drop_en", r, model_word(data_b, dp_b, d_exp), d_exp);
    d_exp = (d_exp + 1) % DIGITS;
    rises = sclk_rises;
    fdt   = fd_total;
    repeat (5000) @(negedge clk);
    check("hold_sclk_rises", 64'(sclk_rises), 64'(rises));
    check("hold_frame_done", 64'(fd_total), 64'(fdt));
    check("hold_digit_idx",  64'(bus.digit_idx), 64'(d_exp));
    bus.scan_en = 1'b1;
    t0 = cyc;
    wait_frame(r, ok);
    if (ok) begin
      check_frame("reenable", r, model_word(data_b, dp_b, d_exp), d_exp);
      check("reenable_latency", 64'(r.fd_cyc - t0), 64'(LATENCY));
    end

    check("ser_stable_in_bit", 64'(glitches), 64'd0);
    check("sclk_rclk_overlap", 64'(overlaps), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg595_scan_ctrl.md
Name: seg595_scan_ctrl

Overview:
- Time-multiplexed scan controller for an 8-digit 7-segment display driven through a 74HC595 shift-register chain.
- Each frame, it selects one digit and decodes that digit's BCD nibble to active-low segments with the existing decode_bcd block.
- It then serialises a 16-bit {seg, sel} word into the chain and pulses the storage latch.
- It sits between the digital-clock time/format logic and the board pins.

Parameters:
- DIGITS, 8: number of digits scanned; frame select width equals DIGITS (fixed 8 in this revision).
- CLK_DIV, 2: clk cycles per sclk half-period; must be ≥1.
- SCAN_CYCLES, 1000: dwell clk cycles in IDLE between frames; must be ≥1.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- scan_en, input, 1: enables frame generation.
- data_in, input, 4*DIGITS: BCD nibble per digit; digit i is data_in[4i+3:4i]. Codes 0–9 show digits, 4'ha shows "-", others are blank.
- dp_en, input, DIGITS: decimal point on for digit i when bit i is 1.
- ser, output, 1: 74HC595 DS serial data.
- sclk, output, 1: 74HC595 SH_CP shift clock.
- rclk, output, 1: 74HC595 ST_CP storage latch.
- digit_idx, output, 3: digit currently being framed.
- frame_done, output, 1: one-cycle pulse at the end of LATCH.

Behaviour:
- Reset values (on any clk edge with rst=1, including mid-frame):
  - ser=0, sclk=0, rclk=0, digit_idx=0, frame_done=0.
  - FSM returns to IDLE; dwell counter, bit counter and divider counter are cleared.
- FSM states are IDLE, LOAD, SHIFT and LATCH.
- IDLE:
  - sclk=0, rclk=0.
  - The dwell counter counts only while scan_en=1.
  - After SCAN_CYCLES counted cycles, go to LOAD.
  - If scan_en=0, hold and keep the count.
- LOAD (1 cycle):
  - Sample data_in nibble[digit_idx] and dp_en[digit_idx] into the decoder.
  - Form word = {seg, sel}, where:
    - seg = decode_bcd output with seg[7] forced to 0 when dp is enabled;
    - sel = one-hot of digit_idx, active-high (digit 0 gives 8'h01).
  - Load the word into the shift register.
  - data_in changes after LOAD have no effect on the current frame.
- SHIFT:
  - 16 bits, MSB first (word[15] first).
  - Per bit: ser is set at bit start; sclk=0 for CLK_DIV cycles, then sclk=1 for CLK_DIV cycles. The rising sclk edge is the shift point.
  - ser is stable for the whole bit.
  - After the 16th high phase, go to LATCH.
- LATCH:
  - sclk=0, rclk=1 for CLK_DIV cycles.
  - On the last cycle, assert frame_done.
  - digit_idx increments, wrapping DIGITS-1 → 0.
  - Go to IDLE; rclk returns to 0.
- Frame period is 1 + 32·CLK_DIV + CLK_DIV + SCAN_CYCLES clk cycles. With defaults: 1+64+2+1000 = 1067.
- scan_en=0 mid-frame: the current frame completes (no torn word), then the FSM holds in IDLE.
- At most one rising edge of sclk per bit. rclk and sclk are never high simultaneously.
- Unused/illegal nibbles (4'hb–4'hf) give seg=8'hff, which is blank.
- dp_en on a blank digit gives 8'h7f.

Decomposition:
- Shared header (included, not duplicated): FRAME_W=16 and the segment constants SEG_BLANK=8'hff and SEG_DP_MASK=8'h7f.
- One sub-module instance: decode_bcd (existing, unmodified), fed from the LOAD-stage nibble.
- The counter/divider logic stays in this module.

Test Plan:
1. Reset then scan_en=1, data_in digit0=4'd5, dp_en=0, CLK_DIV=2, SCAN_CYCLES=4 → after 4 dwell cycles and LOAD, ser emits 16'h9201 MSB-first, sampled on 16 sclk rising edges. rclk is high for 2 cycles, frame_done pulses once, digit_idx becomes 1.
2. Digit0=4'd8 with dp_en[0]=1 → captured word 16'h0001. Digit0=4'ha → 16'hbf01. Digit0=4'hf → 16'hff01.
3. data_in = 32'h76543210, 8 consecutive frames:
   - sel sequence is 01,02,04,…,80, then wraps to 01 on the 9th frame.
   - seg sequence is c0,f9,a4,b0,99,92,82,f8.
   - frame_done is spaced exactly 1 + 33·CLK_DIV + SCAN_CYCLES cycles apart.
4. Change data_in during SHIFT → the shifted word matches the LOAD-time value. The next frame of that digit reflects the new value.
5. Assert rst for 1 cycle at bit 7 of SHIFT → on the next edge all outputs are 0 and digit_idx=0. The following frame is complete and starts with digit 0 after a full SCAN_CYCLES dwell.
6. Drop scan_en at bit 3 of SHIFT → the frame completes with rclk pulse and frame_done, then no further sclk edges for 5000 cycles. Re-assert scan_en → the next frame starts after SCAN_CYCLES with the incremented digit_idx.
